// File: rtl/decode_queue.sv
// RV32I decode stage: decodes each fetched word and buffers the decoded bundle
// in a small FIFO between fetch and execute, with valid/ready on both sides.
package decode_queue_pkg;
  localparam logic [4:0] ALU_X    = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;
  localparam logic [4:0] BR_BEQ   = 5'd11;
  localparam logic [4:0] BR_BNE   = 5'd12;
  localparam logic [4:0] BR_BLT   = 5'd13;
  localparam logic [4:0] BR_BGE   = 5'd14;
  localparam logic [4:0] BR_BLTU  = 5'd15;
  localparam logic [4:0] BR_BGEU  = 5'd16;
  localparam logic [4:0] ALU_JALR = 5'd17;

  localparam logic [1:0] OP1_X   = 2'd0;
  localparam logic [1:0] OP1_RS1 = 2'd1;
  localparam logic [1:0] OP1_PC  = 2'd2;

  localparam logic [2:0] OP2_X   = 3'd0;
  localparam logic [2:0] OP2_RS2 = 3'd1;
  localparam logic [2:0] OP2_IMI = 3'd2;
  localparam logic [2:0] OP2_IMS = 3'd3;
  localparam logic [2:0] OP2_IMJ = 3'd4;
  localparam logic [2:0] OP2_IMU = 3'd5;

  localparam logic [2:0] WB_X   = 3'd0;
  localparam logic [2:0] WB_ALU = 3'd1;
  localparam logic [2:0] WB_MEM = 3'd2;
  localparam logic [2:0] WB_PC  = 3'd3;

  localparam logic MEN_X = 1'b0;
  localparam logic MEN_S = 1'b1;
  localparam logic REN_X = 1'b0;
  localparam logic REN_S = 1'b1;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  op1_addr;
    logic [4:0]  op2_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  exe_fun;
    logic [1:0]  op1;
    logic [2:0]  op2;
    logic [2:0]  wb_sel;
    logic        mem_wen;
    logic        rf_wen;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        illegal;
    logic [1:0]  sys;
  } dec_t;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [PC_W-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_W-1:0]         out_pc,
  output logic [31:0]             out_imm,
  output logic [4:0]              out_op1_addr,
  output logic [4:0]              out_op2_addr,
  output logic [4:0]              out_rd_addr,
  output logic [4:0]              out_exe_fun,
  output logic [1:0]              out_op1,
  output logic [2:0]              out_op2,
  output logic [2:0]              out_wb_sel,
  output logic                    out_mem_wen,
  output logic                    out_rf_wen,
  output logic [1:0]              out_mem_size,
  output logic                    out_mem_unsigned,
  output logic                    out_illegal,
  output logic [1:0]              out_sys,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        dec_illegal;
  dec_t        dec;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    dec.op1_addr = in_inst[19:15];
    dec.op2_addr = in_inst[24:20];
    dec.rd_addr  = in_inst[11:7];
    dec.exe_fun  = ALU_X;
    dec.op1      = OP1_X;
    dec.op2      = OP2_X;
    dec.wb_sel   = WB_X;
    dec.mem_wen  = MEN_X;
    dec.rf_wen   = REN_X;
    dec_illegal  = 1'b0;
    case (opcode)
      7'b0110111: begin
        dec.imm = imm_u; dec.exe_fun = ALU_ADD; dec.op2 = OP2_IMU;
        dec.wb_sel = WB_ALU; dec.rf_wen = REN_S;
      end
      7'b0010111: begin
        dec.imm = imm_u; dec.exe_fun = ALU_ADD; dec.op1 = OP1_PC; dec.op2 = OP2_IMU;
        dec.wb_sel = WB_ALU; dec.rf_wen = REN_S;
      end
      7'b1101111: begin
        dec.imm = imm_j; dec.exe_fun = ALU_ADD; dec.op1 = OP1_PC; dec.op2 = OP2_IMJ;
        dec.wb_sel = WB_PC; dec.rf_wen = REN_S;
      end
      7'b1100111: begin
        dec.imm = imm_i; dec.exe_fun = ALU_JALR; dec.op1 = OP1_RS1; dec.op2 = OP2_IMI;
        dec.wb_sel = WB_PC; dec.rf_wen = REN_S;
        dec_illegal = (funct3 != 3'b000);
      end
      7'b1100011: begin
        dec.imm = imm_b; dec.op1 = OP1_RS1; dec.op2 = OP2_RS2;
        case (funct3)
          3'b000:  dec.exe_fun = BR_BEQ;
          3'b001:  dec.exe_fun = BR_BNE;
          3'b100:  dec.exe_fun = BR_BLT;
          3'b101:  dec.exe_fun = BR_BGE;
          3'b110:  dec.exe_fun = BR_BLTU;
          3'b111:  dec.exe_fun = BR_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.imm = imm_i; dec.exe_fun = ALU_ADD; dec.op1 = OP1_RS1; dec.op2 = OP2_IMI;
        dec.wb_sel = WB_MEM; dec.rf_wen = REN_S;
        dec.mem_size = funct3[1:0]; dec.mem_unsigned = funct3[2];
        dec_illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
      end
      7'b0100011: begin
        dec.imm = imm_s; dec.exe_fun = ALU_ADD; dec.op1 = OP1_RS1; dec.op2 = OP2_IMS;
        dec.mem_wen = MEN_S; dec.mem_size = funct3[1:0];
        dec_illegal = funct3[2] || (funct3[1:0] == 2'b11);
      end
      7'b0010011: begin
        dec.imm = imm_i; dec.op1 = OP1_RS1; dec.op2 = OP2_IMI;
        dec.wb_sel = WB_ALU; dec.rf_wen = REN_S;
        case (funct3)
          3'b000: dec.exe_fun = ALU_ADD;
          3'b010: dec.exe_fun = ALU_SLT;
          3'b011: dec.exe_fun = ALU_SLTU;
          3'b100: dec.exe_fun = ALU_XOR;
          3'b110: dec.exe_fun = ALU_OR;
          3'b111: dec.exe_fun = ALU_AND;
          3'b001: begin
            dec.exe_fun = ALU_SLL;
            dec_illegal = (funct7 != 7'b0000000);
          end
          default: begin
            dec.exe_fun = funct7[5] ? ALU_SRA : ALU_SRL;
            dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
        endcase
      end
      7'b0110011: begin
        dec.op1 = OP1_RS1; dec.op2 = OP2_RS2; dec.wb_sel = WB_ALU; dec.rf_wen = REN_S;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.exe_fun = ALU_ADD;
            3'b001:  dec.exe_fun = ALU_SLL;
            3'b010:  dec.exe_fun = ALU_SLT;
            3'b011:  dec.exe_fun = ALU_SLTU;
            3'b100:  dec.exe_fun = ALU_XOR;
            3'b101:  dec.exe_fun = ALU_SRL;
            3'b110:  dec.exe_fun = ALU_OR;
            default: dec.exe_fun = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.exe_fun = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.exe_fun = ALU_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0001111: ;
      7'b1110011: begin
        if (in_inst == 32'h0000_0073)      dec.sys = 2'b01;
        else if (in_inst == 32'h0010_0073) dec.sys = 2'b10;
        else                               dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal words keep only their raw register fields so the trap handler sees them.
    if (dec_illegal) begin
      dec.imm = '0; dec.exe_fun = ALU_X; dec.op1 = OP1_X; dec.op2 = OP2_X;
      dec.wb_sel = WB_X; dec.mem_wen = MEN_X; dec.rf_wen = REN_X;
      dec.mem_size = 2'b00; dec.mem_unsigned = 1'b0; dec.sys = 2'b00;
    end
    dec.illegal = dec_illegal;
    if (dec.rf_wen == REN_S && dec.rd_addr == 5'd0) dec.rf_wen = REN_X;
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  dec_t          mem_q    [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Asynchronous read keeps the one-cycle push-to-head latency for an empty queue.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q]    <= dec;
      pc_mem_q[wr_ptr_q] <= in_pc;
    end
  end

  dec_t head;
  // Every *_X code is zero, so gating the head to '0 yields the idle bundle.
  assign head             = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_pc           = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign out_imm          = head.imm;
  assign out_op1_addr     = head.op1_addr;
  assign out_op2_addr     = head.op2_addr;
  assign out_rd_addr      = head.rd_addr;
  assign out_exe_fun      = head.exe_fun;
  assign out_op1          = head.op1;
  assign out_op2          = head.op2;
  assign out_wb_sel       = head.wb_sel;
  assign out_mem_wen      = head.mem_wen;
  assign out_rf_wen       = head.rf_wen;
  assign out_mem_size     = head.mem_size;
  assign out_mem_unsigned = head.mem_unsigned;
  assign out_illegal      = head.illegal;
  assign out_sys          = head.sys;
  assign count            = count_q;
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, parametrised RV32I decode stage: decodes each fetched instruction and buffers the decoded bundle in a DEPTH-entry FIFO between fetch and execute, using valid/ready handshakes on both sides.
- Adds over the combinational decoder: the full load/store width set, FENCE/ECALL/EBREAK, illegal-instruction detection, x0 write suppression, PC carry-through and pipeline flush.
- Control encodings (ALU_*, BR_*, OP1_*, OP2_*, WB_*, MEN_*, REN_*) come from the shared define header.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PC_W, 32, width of the carried PC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue accepts the instruction.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  PC of the instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  PC_W  PC of the head entry.
- out_imm  out  32  sign-extended immediate.
- out_op1_addr / out_op2_addr / out_rd_addr  out  5 each  register indices (inst[19:15], [24:20], [11:7]).
- out_exe_fun  out  5  ALU/branch function.
- out_op1  out  2  operand-1 select.
- out_op2  out  3  operand-2 select.
- out_wb_sel  out  3  writeback select.
- out_mem_wen  out  1  store enable.
- out_rf_wen  out  1  register write enable.
- out_mem_size  out  2  00 byte, 01 half, 10 word.
- out_mem_unsigned  out  1  zero-extend load.
- out_illegal  out  1  illegal instruction.
- out_sys  out  2  01 ECALL, 10 EBREAK, 00 otherwise.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, rst=1):
  - Pointers and count go to 0; out_valid=0; in_ready=1.
  - All out_* data fields read as 0 / *_X codes.
- Empty gating: while count==0, out_* fields are forced to 0 / *_X codes, never stale RAM contents.
- Push / pop:
  - Push when in_valid && in_ready. in_ready = (count<DEPTH); it does not depend on out_ready (no full-bypass).
  - Pop when out_valid && out_ready. out_valid = (count!=0).
  - Push and pop in the same cycle leave count unchanged; legal whenever not full.
  - When full, in_ready=0, so a simultaneous pop frees a slot only on the next cycle.
- Latency: an entry pushed at edge N appears at the outputs after edge N, i.e. one cycle, even when the queue is empty. There is no combinational in→out path.
- Pointers wrap modulo DEPTH.
- Flush: at the next edge, count=0 and pointers=0. A push or pop in the flush cycle is discarded. Flush has priority over push and pop.
- Decode is combinational on in_inst and the result is stored at push.
  - LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM and OP use the existing control mapping.
  - Immediates: U {inst[31:12],12'b0}; J, B, S, I per the ISA, sign-extended from inst[31]. Shift immediates use the I format.
  - LOAD (0000011): funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. ALU_ADD, OP1_RS1, OP2_IMI, WB_MEM, REN_S. mem_size = funct3[1:0]; mem_unsigned = funct3[2]. Other funct3 values are illegal.
  - STORE (0100011): funct3 000/001/010 only, giving mem_size 00/01/10, MEN_S, REN_X. Others are illegal.
  - MISC-MEM (0001111): legal NOP (all *_X, illegal=0).
  - SYSTEM (1110011): inst==32'h00000073 gives sys=01; inst==32'h00100073 gives sys=10. Both are otherwise NOP. Any other SYSTEM word is illegal (no CSR support).
  - Illegal conditions:
    - unknown opcode;
    - BRANCH funct3 010 or 011;
    - SLLI with funct7≠0;
    - SRLI/SRAI with funct7∉{0,0100000};
    - OP with funct7∉{0,0100000}, or 0100000 with funct3∉{000,101};
    - JALR funct3≠0.
  - Illegal entries get all *_X codes, mem_wen=MEN_X, rf_wen=REN_X, illegal=1, and are still enqueued in order so the exception stays precise.
  - x0 suppression: if the decoded rf_wen=REN_S and rd==0, store REN_X.
- Reset mid-operation: contents are lost and outputs return to reset values immediately (asynchronous).

Test Plan:
1. Push 0x00500093 (addi x1,x0,5), pc=0x100, out_ready=1 → one cycle later: out_valid=1, imm=5, rd=1, exe_fun=ALU_ADD, op2=OP2_IMI, rf_wen=REN_S, wb_sel=WB_ALU, pc=0x100, illegal=0; popped, count returns to 0.
2. Push 0x0080A103 (lw x2,8(x1)) → imm=8, op1_addr=1, rd=2, wb_sel=WB_MEM, mem_size=10, mem_unsigned=0. Push 0x00000073 → sys=01, rf_wen=REN_X.
3. out_ready=0, push 4 words → count=4, in_ready=0 on the cycle after the 4th push, 5th offer not accepted. Raise out_ready → FIFO order preserved, count decrements by 1 per cycle, wrap verified over 10 pushes.
4. Push 0xFFFFFFFF and 0x00000013 with rd forced to 0 (addi x0) → the first has illegal=1 with all *_X codes; the second has rf_wen=REN_X, illegal=0.
5. count=3, assert flush with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, fields=0. The following push appears after 1 cycle.
6. Assert rst asynchronously mid-clock with count=2 → out_valid=0 and count=0 before the next edge; in_ready=1.
